// File: rtl/gb_joypad_pkg.sv
// Shared constants for the Game Boy joypad bridge: HID usage codes, button bit
// positions in the {start,select,B,A,down,up,left,right} vector, and FSM states.
package gb_joypad_pkg;

  localparam logic [7:0] HID_RIGHT  = 8'h07;
  localparam logic [7:0] HID_LEFT   = 8'h04;
  localparam logic [7:0] HID_UP     = 8'h1A;
  localparam logic [7:0] HID_DOWN   = 8'h16;
  localparam logic [7:0] HID_A      = 8'h0D;
  localparam logic [7:0] HID_B      = 8'h0E;
  localparam logic [7:0] HID_SELECT = 8'h2C;
  localparam logic [7:0] HID_START  = 8'h28;

  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_UP     = 2;
  localparam int BTN_DOWN   = 3;
  localparam int BTN_A      = 4;
  localparam int BTN_B      = 5;
  localparam int BTN_SELECT = 6;
  localparam int BTN_START  = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } hold_state_e;

  function automatic logic [7:0] decode_key(input logic [7:0] code);
    logic [7:0] btn;
    btn = '0;
    case (code)
      HID_RIGHT:  btn[BTN_RIGHT]  = 1'b1;
      HID_LEFT:   btn[BTN_LEFT]   = 1'b1;
      HID_UP:     btn[BTN_UP]     = 1'b1;
      HID_DOWN:   btn[BTN_DOWN]   = 1'b1;
      HID_A:      btn[BTN_A]      = 1'b1;
      HID_B:      btn[BTN_B]      = 1'b1;
      HID_SELECT: btn[BTN_SELECT] = 1'b1;
      HID_START:  btn[BTN_START]  = 1'b1;
      default:    btn = '0;
    endcase
    return btn;
  endfunction

endpackage

// File: rtl/gb_joypad_if.sv
// CPU-side P1 register bus of the joypad: write strobe/data in, read value and
// interrupt request out.
interface gb_joypad_if;
  logic       p1_wr;
  logic [7:0] p1_wdata;
  logic [7:0] p1_rdata;
  logic       joypad_irq;

  modport master (
    output p1_wr,
    output p1_wdata,
    input  p1_rdata,
    input  joypad_irq
  );

  modport slave (
    input  p1_wr,
    input  p1_wdata,
    output p1_rdata,
    output joypad_irq
  );
endinterface

// File: rtl/gb_key_debounce.sv
// Keycode synchroniser and debouncer: a code is accepted into stable once it has
// been seen unchanged for DEBOUNCE_CYCLES consecutive comparisons.
module gb_key_debounce
  import gb_joypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] keycode,
  output logic [7:0] stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       key_q;
  logic [7:0]       cand;
  logic [CNT_W-1:0] cnt;

  // cnt stops at CNT_LAST, so stable keeps being refreshed with the same code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q  <= '0;
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      key_q <= keycode;
      if (key_q != cand) begin
        cand <= key_q;
        cnt  <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= cand;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gb_joypad.sv
// USB-keycode to Game Boy P1 (0xFF00) joypad bridge: debounce, minimum-hold
// press stretching, P1 matrix read-back and high-to-low interrupt detection.
module gb_joypad
  import gb_joypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 833333
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [7:0]        keycode,
  gb_joypad_if.slave        bus,
  output logic [7:0]        btn_state
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [7:0] stable;
  logic [7:0] dec;

  gb_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .keycode (keycode),
    .stable  (stable)
  );

  assign dec = decode_key(stable);

  hold_state_e       state_q, state_d;
  logic [7:0]        btn_out, btn_d;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic              hold_done;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= ST_IDLE;
      btn_out  <= '0;
      hold_cnt <= '0;
    end else begin
      state_q  <= state_d;
      btn_out  <= btn_d;
      hold_cnt <= hold_cnt_d;
    end
  end

  // The last PRESSED cycle already applies the HELD rules, so a short tap
  // drops out after exactly HOLD_CYCLES cycles instead of one more.
  assign hold_done = (state_q == ST_HELD) ||
                     ((state_q == ST_PRESSED) && (hold_cnt == HOLD_LAST));

  always_comb begin
    state_d    = state_q;
    btn_d      = btn_out;
    hold_cnt_d = hold_cnt;

    case (state_q)
      ST_IDLE: begin
        btn_d = '0;
        if (dec != '0) begin
          state_d    = ST_PRESSED;
          btn_d      = dec;
          hold_cnt_d = '0;
        end
      end
      ST_PRESSED: hold_cnt_d = hold_cnt + 1'b1;
      ST_HELD:    ;
      default: begin
        state_d = ST_IDLE;
        btn_d   = '0;
      end
    endcase

    if (hold_done) begin
      state_d = ST_HELD;
      if (dec == '0) begin
        state_d = ST_IDLE;
        btn_d   = '0;
      end else if (dec != btn_out) begin
        state_d    = ST_PRESSED;
        btn_d      = dec;
        hold_cnt_d = '0;
      end
    end
  end

  logic [1:0] sel;
  logic [3:0] nib;
  logic [7:0] rdata_q;
  logic [3:0] low_prev;
  logic       irq_q;
  logic       wdata_unused;

  // P1 lines are active-low; a group is visible only when its select bit is 0
  assign nib = (sel[0] ? 4'h0 : btn_out[3:0]) | (sel[1] ? 4'h0 : btn_out[7:4]);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sel      <= 2'b11;
      rdata_q  <= 8'hFF;
      low_prev <= 4'hF;
      irq_q    <= 1'b0;
    end else begin
      if (bus.p1_wr) begin
        sel <= bus.p1_wdata[5:4];
      end
      rdata_q  <= {2'b11, sel, ~nib};
      low_prev <= rdata_q[3:0];
      irq_q    <= |(low_prev & ~rdata_q[3:0]);
    end
  end

  assign bus.p1_rdata   = rdata_q;
  assign bus.joypad_irq = irq_q;
  assign btn_state      = btn_out;
  assign wdata_unused   = ^{bus.p1_wdata[7:6], bus.p1_wdata[3:0]};

endmodule

// File: doc/gb_joypad.md
GB_JOYPAD -- requirements
Module: gb_joypad

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, consecutive cycles a keycode must be stable before acceptance (1 ms at 50 MHz).
REQ-002 Parameter HOLD_CYCLES, default 833333, minimum cycles a newly pressed button stays asserted (about one 60 Hz frame).
REQ-003 clk_clk  input  1  system clock; the only clock.
REQ-004 reset_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 keycode  input  8  USB HID usage code of the currently pressed key; 0x00 means none.
REQ-006 p1_wr  input  1  CPU write strobe to P1 (0xFF00), one cycle.
REQ-007 p1_wdata  input  8  CPU write data; only bits 5:4 are used.
REQ-008 p1_rdata  output  8  registered P1 read value.
REQ-009 joypad_irq  output  1  one-cycle joypad interrupt request pulse.
REQ-010 btn_state  output  8  debug view {start,select,B,A,down,up,left,right}, active-high.

Function
REQ-011 keycode SHALL be registered into key_q every cycle.
REQ-012 Debounce SHALL work as follows: if key_q != cand, then cand<=key_q and cnt<=0; else if cnt==DEBOUNCE_CYCLES-1, then stable<=cand; else cnt increments. cnt saturates.
REQ-013 Decode of stable SHALL be: 0x07 right, 0x04 left, 0x1A up, 0x16 down, 0x0D A, 0x0E B, 0x2C select, 0x28 start. Any other code decodes to 0 (no button).
REQ-014 Hold FSM SHALL have states IDLE, PRESSED and HELD, with btn_out as its output register.
REQ-015 IDLE: btn_out=0. When decode!=0, go to PRESSED with btn_out<=decode and hold_cnt<=0.
REQ-016 PRESSED: hold_cnt increments and decode changes are ignored. When hold_cnt==HOLD_CYCLES-1, go to HELD.
REQ-017 HELD: if decode==0, go to IDLE with btn_out<=0. If decode is nonzero and != btn_out, go to PRESSED with btn_out<=decode and hold_cnt<=0. Otherwise stay.
REQ-018 A tap shorter than HOLD_CYCLES (after debounce) SHALL still produce exactly HOLD_CYCLES cycles of btn_out asserted.
REQ-019 p1_wr SHALL load sel<=p1_wdata[5:4]. sel resets to 2'b11.
REQ-020 Each cycle, p1_rdata SHALL be set to {2'b11, sel, ~nib}, where nib = (sel[0]==0 ? {down,up,left,right} : 0) | (sel[1]==0 ? {start,select,B,A} : 0).
REQ-021 A p1_wr in the same cycle as a btn_out change SHALL make the next p1_rdata reflect both the new sel and the new btn_out.
REQ-022 joypad_irq SHALL be 1 for the single cycle after any p1_rdata[3:0] bit goes 1->0 between consecutive cycles. Bit changes 0->1 and changes caused only by sel SHALL still follow this same rule.
REQ-023 End-to-end latency from a keycode change at the input to p1_rdata SHALL be DEBOUNCE_CYCLES+3 cycles, with no hold deferral.
REQ-024 btn_state SHALL equal btn_out.

Reset
REQ-025 On reset_reset_n=0, all state SHALL clear immediately: key_q=0, cand=0, cnt=0, stable=0, FSM=IDLE, btn_out=0, hold_cnt=0, sel=2'b11, p1_rdata=0xFF, joypad_irq=0.
REQ-026 Reset asserted mid-press or mid-hold SHALL abandon the press. After release, no IRQ is generated unless a new press is debounced.

Structure
REQ-027 Package gb_joypad_pkg SHALL hold the HID code constants, the button-bit index constants, and the FSM state enum.
REQ-028 The debounce logic (key_q, cand, cnt, stable) SHALL be one sub-module, gb_key_debounce, parameterised by DEBOUNCE_CYCLES. The FSM and P1 logic stay in gb_joypad.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10)
REQ-029 Reset, then idle -> p1_rdata=0xFF, joypad_irq=0 and btn_state=0x00 throughout.
REQ-030 Write 0x20, then hold keycode=0x04 -> p1_rdata=0xED exactly 7 cycles after keycode is applied, and joypad_irq pulses once, one cycle later.
REQ-031 Write 0x20, hold keycode=0x04 for 3 cycles, then 0x00 -> p1_rdata stays 0xEF and no IRQ occurs.
REQ-032 Write 0x10, apply keycode=0x28 until debounced, then release immediately -> p1_rdata=0xD7 for exactly 10 cycles, then 0xDF after debounce of 0x00. One IRQ total.
REQ-033 Write 0x00, hold keycode=0x07 -> p1_rdata=0xCE. Then write 0x30 -> next p1_rdata=0xFF with no IRQ. Then write 0x20 -> 0xEE with one IRQ.
REQ-034 Hold keycode=0x1A in the HELD state, then assert reset_reset_n=0 for 2 cycles -> p1_rdata=0xFF at once. After release, with keycode still 0x1A and 0x20 written, 0xEB follows after the debounce latency with one IRQ.
